// File: rtl/cmp_sort_pkg.sv
// Shared types and constants for the compare-driven bubble sorter.
package cmp_sort_pkg;

  localparam int unsigned CODE_W = 2;

  // Magnitude-compare result codes produced by cmp_code.
  localparam logic [CODE_W-1:0] CMP_LT = 2'd0;
  localparam logic [CODE_W-1:0] CMP_EQ = 2'd1;
  localparam logic [CODE_W-1:0] CMP_GT = 2'd2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_code.sv
// W-bit unsigned magnitude comparator producing the 2-bit result code.
module cmp_code
  import cmp_sort_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [CODE_W-1:0] code
);

  // Unsigned compare over exactly W bits.
  always_comb begin
    code = CMP_LT;
    if (a > b) begin
      code = CMP_GT;
    end else if (a == b) begin
      code = CMP_EQ;
    end
  end

endmodule

// File: rtl/cmp_bubble_sorter.sv
// Batch bubble sorter: loads N elements, sorts in place with one
// compare-and-swap per cycle, then streams the sorted batch out.
// Optional macro CMP_SORT_EARLY_EXIT_EN ends the sort after the first
// pass that makes no swap.
module cmp_bubble_sorter
  import cmp_sort_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 3,
  parameter bit          DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned JW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 2);

  state_t              state;
  state_t              state_nx;
  logic [W-1:0]        mem [N];
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       k;
  logic [JW-1:0]       j;
  logic [JW-1:0]       pass;
  logic [CW-1:0]       ia;
  logic [CW-1:0]       ib;
  logic [CODE_W-1:0]   code;
  logic                swap;
  logic                load_fire;
  logic                load_last;
  logic                pass_end;
  logic                sort_end;
  logic                drain_fire;
  logic                drain_last;

  assign ia = CW'(j);
  assign ib = ia + CW'(1);

  cmp_code #(.W(W)) u_cmp (
    .a    (mem[ia]),
    .b    (mem[ib]),
    .code (code)
  );

  // Swap decision and per-state handshake/termination conditions.
  always_comb begin
    swap       = DESCEND ? (code == CMP_LT) : (code == CMP_GT);
    load_fire  = (state == LOAD) && in_valid;
    load_last  = load_fire && (cnt == C_LAST);
    pass_end   = (j == J_LAST);
    drain_fire = (state == DRAIN) && out_ready;
    drain_last = drain_fire && (k == C_LAST);
  end

`ifdef CMP_SORT_EARLY_EXIT_EN
  logic swapped;
  logic pass_swapped;

  // Swap history of the current pass, restarted at j==0.
  always_comb begin
    pass_swapped = (j == '0) ? swap : (swapped | swap);
    sort_end     = (state == SORT) && pass_end &&
                   ((pass == J_LAST) || !pass_swapped);
  end

  // Carry the swap history across the pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swapped <= 1'b0;
    end else if (state == SORT) begin
      swapped <= pass_swapped;
    end
  end
`else
  // Fixed-length sort: ends after the last compare of the last pass.
  always_comb begin
    sort_end = (state == SORT) && pass_end && (pass == J_LAST);
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_last)  state_nx = SORT;
      SORT:    if (sort_end)   state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Output decode from the state register and drain pointer.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state)
      LOAD:  in_ready = 1'b1;
      SORT:  busy = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = mem[k];
      end
      default: ;
    endcase
  end

  // Buffer, counters and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        mem[i] <= '0;
      end
      cnt  <= '0;
      k    <= '0;
      j    <= '0;
      pass <= '0;
      done <= 1'b0;
    end else begin
      done <= drain_last;
      case (state)
        LOAD: begin
          if (load_fire) begin
            mem[cnt] <= in_data;
            cnt      <= load_last ? '0 : cnt + CW'(1);
          end
        end
        SORT: begin
          if (swap) begin
            mem[ia] <= mem[ib];
            mem[ib] <= mem[ia];
          end
          if (sort_end) begin
            j    <= '0;
            pass <= '0;
          end else if (pass_end) begin
            j    <= '0;
            pass <= pass + JW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            k <= drain_last ? '0 : k + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_bubble_sorter.sv
// Directed bench for cmp_bubble_sorter: ascending and descending instances
// share the input stream; sorted outputs are checked against fixed tables.
// Honours CMP_SORT_EARLY_EXIT_EN for the expected sort latency.
module tb_cmp_bubble_sorter;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, busy_a, done_a;
  logic [W-1:0] out_data_a;
  logic         in_ready_d, out_valid_d, busy_d, done_d;
  logic [W-1:0] out_data_d;

  always #5 clk = ~clk;

  cmp_bubble_sorter #(.N(N), .W(W), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ready(out_ready), .busy(busy_a), .done(done_a)
  );

  cmp_bubble_sorter #(.N(N), .W(W), .DESCEND(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
    .out_ready(out_ready), .busy(busy_d), .done(done_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int vin   [5][8];
  int easc  [5][8];
  int edesc [5][8];

  int qa[$];
  int qd[$];
  int done_a_cnt = 0;
  int done_d_cnt = 0;
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_val  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transfer monitor: collects outputs, counts done pulses, checks hold.
  always @(posedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (out_valid_a && out_ready) qa.push_back(int'(out_data_a));
      if (out_valid_d && out_ready) qd.push_back(int'(out_data_d));
      if (done_a) begin
        done_a_cnt++;
        chk("done_with_in_ready", 32'(in_ready_a), 32'd1);
      end
      if (done_d) done_d_cnt++;
      if (hold_pend && out_valid_a) chk("hold_out_data", 32'(out_data_a), 32'(hold_val));
      hold_pend = out_valid_a && !out_ready;
      hold_val  = out_data_a;
    end
  end

  task automatic load(input int b);
    int t;
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'(vin[b][i]);
      t = 0;
      while (!(in_ready_a && in_ready_d) && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("load_timeout", 32'd0, 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic drain(input int b, input bit bp, input bit garbage, input int exp_lat);
    int n;
    int lat;
    int pc;
    n = 0;
    lat = -1;
    pc = 0;
    qa.delete();
    qd.delete();
    done_a_cnt = 0;
    done_d_cnt = 0;
    while ((qa.size() < int'(N) || qd.size() < int'(N)) && n < 400) begin
      @(negedge clk);
      n++;
      if (qa.size() >= int'(N) || qd.size() >= int'(N)) begin
        in_valid = 1'b0;
        in_data  = '0;
      end else begin
        in_valid = garbage;
        in_data  = garbage ? 3'd7 : 3'd0;
      end
      if (out_valid_a && lat < 0) lat = n;
      if (bp && out_valid_a) begin
        out_ready = (pc % 2 == 0);
        pc++;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("drain_timeout", 32'(n < 400), 32'd1);
    repeat (3) @(negedge clk);
    if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("count_asc", 32'(qa.size()), 32'(N));
    chk("count_desc", 32'(qd.size()), 32'(N));
    for (int i = 0; i < int'(N); i++) begin
      if (i < qa.size()) chk($sformatf("asc_b%0d_e%0d", b, i), 32'(qa[i]), 32'(easc[b][i]));
      if (i < qd.size()) chk($sformatf("desc_b%0d_e%0d", b, i), 32'(qd[i]), 32'(edesc[b][i]));
    end
    chk("done_pulses_asc", 32'(done_a_cnt), 32'd1);
    chk("done_pulses_desc", 32'(done_d_cnt), 32'd1);
    chk("idle_in_ready", 32'(in_ready_a), 32'd1);
    chk("idle_busy", 32'(busy_a), 32'd0);
  endtask

  initial begin
    vin   = '{'{5,1,7,0,3,3,6,2}, '{4,4,0,7,2,6,1,5}, '{7,6,5,4,3,2,1,0},
              '{6,2,2,5,0,7,3,1}, '{0,1,2,3,4,5,6,7}};
    easc  = '{'{0,1,2,3,3,5,6,7}, '{0,1,2,4,4,5,6,7}, '{0,1,2,3,4,5,6,7},
              '{0,1,2,2,3,5,6,7}, '{0,1,2,3,4,5,6,7}};
    edesc = '{'{7,6,5,3,3,2,1,0}, '{7,6,5,4,4,2,1,0}, '{7,6,5,4,3,2,1,0},
              '{7,6,5,3,2,2,1,0}, '{7,6,5,4,3,2,1,0}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data", 32'(out_data_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;

    // Mixed data with a duplicate pair.
    load(0);
`ifdef CMP_SORT_EARLY_EXIT_EN
    drain(0, 1'b0, 1'b0, 0);
`else
    drain(0, 1'b0, 1'b0, 50);
`endif

    // Output backpressure, out_ready alternating 1,0,1,0.
    load(1);
    drain(1, 1'b1, 1'b0, 0);

    // Reset in the middle of SORT discards the batch.
    load(2);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid_sort_busy", 32'(busy_a), 32'd1);
    chk("mid_sort_out_valid", 32'(out_valid_a), 32'd0);
    qa.delete();
    qd.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("post_rst_busy", 32'(busy_a), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("post_rst_busy_desc", 32'(busy_d), 32'd0);
    repeat (2) @(negedge clk);
    chk("post_rst_no_output", 32'(qa.size()), 32'd0);
    load(2);
    drain(2, 1'b0, 1'b0, 0);

    // in_valid held high with data 7 through SORT and DRAIN.
    load(3);
    drain(3, 1'b0, 1'b1, 0);

    // Already-sorted input.
    load(4);
`ifdef CMP_SORT_EARLY_EXIT_EN
    drain(4, 1'b0, 1'b0, 8);
`else
    drain(4, 1'b0, 1'b0, 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
